// File: rtl/sr_flag_pkg.sv
// Shared constants and helpers for the sr_flag_bank set/reset flag array.
package sr_flag_pkg;

  localparam int SR_SET_DOM = 0;
  localparam int SR_RST_DOM = 1;
  localparam int SR_HOLD    = 2;
  localparam int SR_TOGGLE  = 3;

  localparam int POP_W = 6;

  function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {{(POP_W-1){1'b0}}, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sr_flag_bank_sync.sv
// Single-bit synchroniser chain of depth DEPTH; DEPTH=0 passes the input straight through.
module sr_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [DEPTH-1:0] ff;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ff <= '0;
      end else begin
        ff[0] <= d;
        for (int i = 1; i < DEPTH; i++) ff[i] <= ff[i-1];
      end
    end
    assign q = ff[DEPTH-1];
  end

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of CH clocked set/reset flags with synchronised inputs, conflict policy,
// optional edge triggering and a saturating conflict counter.
module sr_flag_bank
  import sr_flag_pkg::*;
#(
  parameter int CH          = 4,
  parameter int MODE        = 0,
  parameter int EDGE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    set,
  input  logic [CH-1:0]    reset,
  input  logic             clr_cnt,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    q_bar,
  output logic [CH-1:0]    conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [CH-1:0]    s_p0, r_p0;
  logic [CH-1:0]    s_hist_p1, r_hist_p1;
  logic [CH-1:0]    s_eff, r_eff;
  logic [CH-1:0]    q_p1, q_nxt, cf_nxt;
  logic [CH-1:0]    cf_p1;
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [CNT_W+POP_W:0] s;
    s = {{(POP_W+1){1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
    return (s[CNT_W+POP_W:CNT_W] != '0) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Stage p0: per-bit synchronisers
  for (genvar i = 0; i < CH; i++) begin : g_sync
    sr_sync #(.DEPTH(SYNC_STAGES)) u_s (.clk(clk), .rst_n(rst_n), .d(set[i]),   .q(s_p0[i]));
    sr_sync #(.DEPTH(SYNC_STAGES)) u_r (.clk(clk), .rst_n(rst_n), .d(reset[i]), .q(r_p0[i]));
  end

  assign s_eff = (EDGE != 0) ? (s_p0 & ~s_hist_p1) : s_p0;
  assign r_eff = (EDGE != 0) ? (r_p0 & ~r_hist_p1) : r_p0;

  always_comb begin
    q_nxt  = q_p1;
    cf_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      case ({s_eff[i], r_eff[i]})
        2'b10: q_nxt[i] = 1'b1;
        2'b01: q_nxt[i] = 1'b0;
        2'b11: begin
          cf_nxt[i] = 1'b1;
          case (MODE)
            SR_SET_DOM: q_nxt[i] = 1'b1;
            SR_RST_DOM: q_nxt[i] = 1'b0;
            SR_TOGGLE:  q_nxt[i] = ~q_p1[i];
            default:    q_nxt[i] = q_p1[i];
          endcase
        end
        default: q_nxt[i] = q_p1[i];
      endcase
    end
  end

  // Stage p1: flag state, edge history, conflict flags and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p1      <= '0;
      s_hist_p1 <= '0;
      r_hist_p1 <= '0;
      cf_p1     <= '0;
      cnt_p1    <= '0;
    end else begin
      q_p1      <= q_nxt;
      s_hist_p1 <= s_p0;
      r_hist_p1 <= r_p0;
      cf_p1     <= cf_nxt;
      cnt_p1    <= clr_cnt ? '0 : sat_add(cnt_p1, popcount(32'(cf_nxt)));
    end
  end

  // Both polarities come from one register so they can never agree.
  assign q            = q_p1;
  assign q_bar        = ~q_p1;
  assign conflict     = cf_p1;
  assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: four policy variants, an edge-mode and a bypass-sync instance.
module tb_sr_flag_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] set_a, reset_a;
  logic       clr_a;
  logic [3:0] qa [4];
  logic [3:0] qba [4];
  logic [3:0] cfa [4];
  logic [7:0] cna [4];

  logic [3:0] set_e, reset_e, q_e, qb_e, cf_e;
  logic [7:0] cn_e;
  logic [3:0] set_z, reset_z, q_z, qb_z, cf_z;
  logic [7:0] cn_z;
  logic       clr_0;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_e3 [4] = '{4'h4, 4'h0, 4'h4, 4'h0};
  logic [3:0] exp_e4 [4] = '{4'h4, 4'h0, 4'h4, 4'h4};
  logic [3:0] exp_e5 [4] = '{4'h4, 4'h0, 4'h4, 4'h0};

  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_flag_bank #(.CH(4), .MODE(m), .EDGE(0), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .set(set_a), .reset(reset_a), .clr_cnt(clr_a),
      .q(qa[m]), .q_bar(qba[m]), .conflict(cfa[m]), .conflict_cnt(cna[m]));
  end

  sr_flag_bank #(.CH(4), .MODE(0), .EDGE(1), .SYNC_STAGES(2), .CNT_W(8)) u_edge (
    .clk(clk), .rst_n(rst_n), .set(set_e), .reset(reset_e), .clr_cnt(clr_0),
    .q(q_e), .q_bar(qb_e), .conflict(cf_e), .conflict_cnt(cn_e));

  sr_flag_bank #(.CH(4), .MODE(0), .EDGE(0), .SYNC_STAGES(0), .CNT_W(8)) u_nosync (
    .clk(clk), .rst_n(rst_n), .set(set_z), .reset(reset_z), .clr_cnt(clr_0),
    .q(q_z), .q_bar(qb_z), .conflict(cf_z), .conflict_cnt(cn_z));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    logic [3:0] inv;
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 4; m++) begin
        inv = ~qa[m];
        chk("qbar_mode", {28'h0, qba[m]}, {28'h0, inv});
      end
      inv = ~q_e;
      chk("qbar_edge", {28'h0, qb_e}, {28'h0, inv});
    end
  endtask

  initial begin
    rst_n = 1'b1; clr_0 = 1'b0;
    set_a = '0; reset_a = '0; clr_a = 1'b0;
    set_e = 4'b0001; reset_e = '0;
    set_z = '0; reset_z = '0;

    // power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q",     {28'h0, qa[0]},  32'h0);
    chk("rst_qbar",  {28'h0, qba[0]}, 32'hF);
    chk("rst_cf",    {28'h0, cfa[0]}, 32'h0);
    chk("rst_cnt",   {24'h0, cna[0]}, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("edge_rel_early", {28'h0, q_e}, 32'h0);
    step(1);
    chk("edge_rel_set", {28'h0, q_e}, 32'h1);

    // basic set then reset on channel 0
    set_a = 4'b0001;
    step(2);
    set_a = '0;
    chk("basic_lat", {28'h0, qa[0]}, 32'h0);
    step(1);
    chk("basic_set", {28'h0, qa[0]}, 32'h1);
    step(3);
    chk("basic_hold", {28'h0, qa[0]}, 32'h1);
    reset_a = 4'b0001;
    step(2);
    reset_a = '0;
    chk("basic_rlat", {28'h0, qa[0]}, 32'h1);
    step(1);
    chk("basic_clr", {28'h0, qa[0]}, 32'h0);
    chk("basic_cnt", {24'h0, cna[0]}, 32'h0);

    // preset channel 2, then S=R=1 for three cycles under each policy
    set_a = 4'b0100;
    step(2);
    set_a = '0;
    step(1);
    for (int m = 0; m < 4; m++) chk("pre_q2", {28'h0, qa[m]}, 32'h4);
    set_a = 4'b0100; reset_a = 4'b0100;
    step(3);
    set_a = '0; reset_a = '0;
    for (int m = 0; m < 4; m++) begin
      chk("cf_q_e3",  {28'h0, qa[m]},  {28'h0, exp_e3[m]});
      chk("cf_cf_e3", {28'h0, cfa[m]}, 32'h4);
      chk("cf_cnt1",  {24'h0, cna[m]}, 32'h1);
    end
    step(1);
    for (int m = 0; m < 4; m++) begin
      chk("cf_q_e4",  {28'h0, qa[m]},  {28'h0, exp_e4[m]});
      chk("cf_cnt2",  {24'h0, cna[m]}, 32'h2);
    end
    step(1);
    for (int m = 0; m < 4; m++) begin
      chk("cf_q_e5",  {28'h0, qa[m]},  {28'h0, exp_e5[m]});
      chk("cf_cf_e5", {28'h0, cfa[m]}, 32'h4);
      chk("cf_cnt3",  {24'h0, cna[m]}, 32'h3);
    end
    step(1);
    for (int m = 0; m < 4; m++) begin
      chk("cf_off",   {28'h0, cfa[m]}, 32'h0);
      chk("cf_cnt3b", {24'h0, cna[m]}, 32'h3);
    end

    // all channels conflicting: saturation, then clear
    set_a = 4'hF; reset_a = 4'hF;
    step(3);
    chk("sat_first", {24'h0, cna[0]}, 32'd7);
    chk("sat_cf",    {28'h0, cfa[0]}, 32'hF);
    step(62);
    chk("sat_255", {24'h0, cna[0]}, 32'd255);
    step(5);
    chk("sat_nowrap", {24'h0, cna[0]}, 32'd255);
    chk("sat_nowrap3", {24'h0, cna[3]}, 32'd255);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    chk("clr_cnt0", {24'h0, cna[0]}, 32'd0);
    chk("clr_cf",   {28'h0, cfa[0]}, 32'hF);
    step(1);
    chk("clr_resume4", {24'h0, cna[0]}, 32'd4);
    step(1);
    chk("clr_resume8", {24'h0, cna[0]}, 32'd8);
    reset_a = '0;
    step(3);
    chk("drain_cnt", {24'h0, cna[0]}, 32'd16);
    chk("drain_cf",  {28'h0, cfa[0]}, 32'h0);
    for (int m = 0; m < 4; m++) chk("drain_q", {28'h0, qa[m]}, 32'hF);

    // edge mode on channel 1: reset pulse, held set, reset edge under held set
    reset_e = 4'b0010;
    step(1);
    reset_e = '0; set_e = 4'b0011;
    step(3);
    chk("edge_set", {28'h0, q_e}, 32'h3);
    step(4);
    chk("edge_hold", {28'h0, q_e}, 32'h3);
    chk("edge_nocf", {28'h0, cf_e}, 32'h0);
    reset_e = 4'b0010;
    step(2);
    chk("edge_rlat", {28'h0, q_e}, 32'h3);
    step(1);
    chk("edge_rst", {28'h0, q_e}, 32'h1);
    step(4);
    chk("edge_rst_hold", {28'h0, q_e}, 32'h1);
    chk("edge_cnt", {24'h0, cn_e}, 32'h0);
    set_e = 4'b0001; reset_e = '0;

    // zero-depth synchroniser: one-edge latency
    set_z = 4'b1000;
    #1;
    chk("nosync_pre", {28'h0, q_z}, 32'h0);
    step(1);
    chk("nosync_set", {28'h0, q_z}, 32'h8);
    chk("nosync_qbar", {28'h0, qb_z}, 32'h7);
    set_z = '0; reset_z = 4'b1000;
    step(1);
    chk("nosync_rst", {28'h0, q_z}, 32'h0);
    reset_z = '0;

    // asynchronous reset mid-run with set held high
    chk("pre_rst_cnt", {24'h0, cna[0]}, 32'd16);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q",    {28'h0, qa[0]},  32'h0);
    chk("mid_rst_qbar", {28'h0, qba[0]}, 32'hF);
    chk("mid_rst_cnt",  {24'h0, cna[0]}, 32'h0);
    chk("mid_rst_qe",   {28'h0, q_e},    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    chk("rel_q_early",  {28'h0, qa[0]}, 32'h0);
    chk("rel_qe_early", {28'h0, q_e},   32'h0);
    step(1);
    chk("rel_q_set",  {28'h0, qa[0]}, 32'hF);
    chk("rel_qe_set", {28'h0, q_e},   32'h1);
    chk("rel_cnt",    {24'h0, cna[0]}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
